gray_decode_arbiter: RTL and testbench
======================================

GRAY_DECODE_ARBITER -- requirements
Module: gray_decode_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the converter; fixed at 4 for this release.
REQ-002 Parameter W, default 4: gray/binary code width.
REQ-003 Parameter CNT_W, default 16: width of the accepted-transaction counter.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 req_valid  in  N_REQ  bit i set: requester i presents a code.
REQ-007 req_gray  in  N_REQ*W  packed codes; requester i at bits [i*W +: W].
REQ-008 req_ready  out  N_REQ  one-hot-or-zero; bit i set: requester i accepted this cycle.
REQ-009 rsp_valid  out  1  the response register holds a result.
REQ-010 rsp_bin  out  W  binary equivalent of the accepted gray code.
REQ-011 rsp_id  out  2  index of the requester that owns rsp_bin.
REQ-012 rsp_ready  in  1  the consumer takes the response this cycle.
REQ-013 accept_cnt  out  CNT_W  count of accepted requests, wrapping modulo 2^CNT_W.

Function
REQ-014 Conversion SHALL be bin[W-1]=gray[W-1] and bin[k]=bin[k+1] XOR gray[k] for k=W-2..0.
REQ-015 The response slot is free when rsp_valid=0 or rsp_ready=1; acceptance is possible only in a cycle with a free slot.
REQ-016 With a free slot and any req_valid set, the block SHALL assert exactly one req_ready bit for the round-robin winner; otherwise all req_ready bits SHALL be 0.
REQ-017 The round-robin search SHALL start at index (last_grant+1) mod N_REQ and proceed upward with wrap.
REQ-018 last_grant SHALL update only on acceptance.
REQ-019 req_ready SHALL be combinational from req_valid, rsp_valid, rsp_ready and the arbitration pointer.
REQ-020 req_ready SHALL NOT depend on req_gray.
REQ-021 Latency SHALL be one cycle: the converted code is loaded on the accepting edge, with rsp_valid=1 and rsp_id set to the winner.
REQ-022 If rsp_valid=1 and rsp_ready=0, rsp_bin and rsp_id SHALL hold stable and no request SHALL be accepted.
REQ-023 Simultaneous drain and accept (rsp_valid=1, rsp_ready=1, request pending) SHALL replace the slot in the same edge, sustaining 1 result/cycle.
REQ-024 Drain with no pending request SHALL clear rsp_valid on that edge; rsp_bin and rsp_id retain their last values.
REQ-025 Control SHALL be a two-state FSM.
REQ-026 FSM state EMPTY: go to FULL on acceptance.
REQ-027 FSM state FULL: stay in FULL on drain+accept or stall; go to EMPTY on drain with no acceptance.
REQ-028 rsp_valid SHALL equal (state==FULL).
REQ-029 accept_cnt SHALL increment by 1 on each acceptance and wrap from all-ones to 0.
REQ-030 Requesters SHALL hold req_valid and req_gray until their req_ready.
REQ-031 Deasserting req_valid before req_ready is legal; that request is simply not served.

Reset
REQ-032 On a rising edge with rst_n=0, the block SHALL force state=EMPTY, rsp_valid=0, rsp_bin=0, rsp_id=0, accept_cnt=0 and last_grant=N_REQ-1, so requester 0 has first priority.
REQ-033 While rst_n=0, req_ready SHALL be all 0.
REQ-034 Reset mid-transaction SHALL discard any held response without further handshake.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (EMPTY, FULL) and the defaults for N_REQ, W and CNT_W.
REQ-036 The conversion SHALL live in one combinational sub-module, gray_to_bin_core (W-parameterised).
REQ-037 gray_to_bin_core SHALL be instantiated once, fed by the winner's code through an N_REQ:1 mux.

Verification
REQ-038 Single request: after reset, req_valid=4'b0100 with req_gray lane2=4'b1011 -> req_ready=4'b0100 the same cycle; next cycle rsp_valid=1, rsp_bin=4'b1101, rsp_id=2, accept_cnt=1.
REQ-039 Fairness: all four lanes valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one rsp per cycle, no idle cycles.
REQ-040 Backpressure: accept lane0 code 4'b1000 (rsp_bin=4'b1111), then hold rsp_ready=0 for 3 cycles with lanes 1 and 3 valid -> req_ready=0, response stable; when rsp_ready=1, lane1 is granted on that same cycle.
REQ-041 Exhaustive mapping: lane3 alone steps through all 16 gray codes -> responses match REQ-014 (0010->0011, 0110->0100, 1111->1010); accept_cnt=16.
REQ-042 Reset mid-operation: hold rsp_valid=1 stalled, assert rst_n=0 one cycle -> next cycle rsp_valid=0, accept_cnt=0; with all lanes then valid, the first grant goes to lane0.
REQ-043 Counter wrap: preload by running 2^CNT_W acceptances (or use CNT_W=4 override with 16) -> accept_cnt returns to 0 and continues counting.

Source files
------------

// File: rtl/gray_decode_arbiter_pkg.sv
// Shared definitions for the gray-decode arbiter: parameter defaults and
// the response-slot FSM state encoding.
package gray_decode_arbiter_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned W_DEF     = 4;
   localparam int unsigned CNT_W_DEF = 16;

   // Response slot occupancy
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/gray_decode_arbiter_g2b.sv
// Purely combinational gray-to-binary converter.
// Each binary bit is the XOR of all gray bits at or above its position,
// which equals the ripple form bin[k] = bin[k+1] ^ gray[k].
module gray_to_bin_core #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Prefix-XOR from the MSB down
   always_comb begin
      bin = '0;
      for (int unsigned k = 0; k < W; k++) begin
         bin[k] = ^(gray >> k);
      end
   end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter in front of a single shared gray-to-binary converter,
// with a one-entry response register and an accepted-request counter.
module gray_decode_arbiter
   import gray_decode_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*W-1:0]   req_gray,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 rsp_valid,
   output logic [W-1:0]         rsp_bin,
   output logic [1:0]           rsp_id,
   input  logic                 rsp_ready,
   output logic [CNT_W-1:0]     accept_cnt
);

   state_t             state_q;
   state_t             state_d;
   logic [1:0]         last_grant_q;
   logic [1:0]         winner;
   logic [N_REQ-1:0]   grant;
   logic               slot_free;
   logic               accept;
   logic [W-1:0]       sel_gray;
   logic [W-1:0]       sel_bin;
   logic [W-1:0]       rsp_bin_q;
   logic [1:0]         rsp_id_q;
   logic [CNT_W-1:0]   cnt_q;

   assign rsp_valid  = (state_q == FULL);
   assign slot_free  = (state_q == EMPTY) || rsp_ready;
   assign accept     = |grant;
   assign req_ready  = grant;
   assign rsp_bin    = rsp_bin_q;
   assign rsp_id     = rsp_id_q;
   assign accept_cnt = cnt_q;

   // Round-robin pick: scan upward from the lane after the last grant
   always_comb begin
      int unsigned idx;
      logic        found;
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      if (rst_n && slot_free) begin
         for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = (32'(last_grant_q) + off) % N_REQ;
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               winner     = 2'(idx);
            end
         end
      end
   end

   // Winner's code into the single shared converter
   always_comb begin
      sel_gray = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (winner == 2'(i)) begin
            sel_gray = req_gray[i*W +: W];
         end
      end
   end

   gray_to_bin_core #(
      .W (W)
   ) u_g2b (
      .gray (sel_gray),
      .bin  (sel_bin)
   );

   // Slot occupancy: fill on accept, empty on drain without refill
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (accept)         state_d = FULL;
            else if (rsp_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Response payload, pointer and counter advance only on acceptance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_bin_q    <= '0;
         rsp_id_q     <= '0;
         cnt_q        <= '0;
         last_grant_q <= 2'(N_REQ - 1);
      end else if (accept) begin
         rsp_bin_q    <= sel_bin;
         rsp_id_q     <= winner;
         cnt_q        <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         last_grant_q <= winner;
      end
   end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter: reset, single request, fairness,
// backpressure, full gray mapping, mid-operation reset and counter wrap.
module tb_gray_decode_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_gray;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [3:0]  rsp_bin;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic [15:0] accept_cnt;

   int errors = 0;
   int checks = 0;

   // gray code g -> binary, worked out by hand
   logic [3:0] exp_bin [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0111, 4'b0110, 4'b0100, 4'b0101,
                                4'b1111, 4'b1110, 4'b1100, 4'b1101,
                                4'b1000, 4'b1001, 4'b1011, 4'b1010};

   gray_decode_arbiter #(
      .N_REQ (4),
      .W     (4),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_gray   (req_gray),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_bin    (rsp_bin),
      .rsp_id     (rsp_id),
      .rsp_ready  (rsp_ready),
      .accept_cnt (accept_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // lane codes for fairness: 0110->0100, 1111->1010, 1011->1101, 0010->0011
      logic [3:0] fair_gray [4] = '{4'b0110, 4'b1111, 4'b1011, 4'b0010};
      logic [3:0] fair_bin  [4] = '{4'b0100, 4'b1010, 4'b1101, 4'b0011};

      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_gray  = '0;
      rsp_ready = 1'b0;
      #1;
      check("ready_in_reset", 32'(req_ready), 32'h0);
      tick();
      tick();
      check("rst_valid", 32'(rsp_valid), 32'h0);
      check("rst_bin", 32'(rsp_bin), 32'h0);
      check("rst_id", 32'(rsp_id), 32'h0);
      check("rst_cnt", 32'(accept_cnt), 32'h0);
      check("ready_in_reset2", 32'(req_ready), 32'h0);

      // Single request on lane 2
      do_reset();
      req_valid = 4'b0100;
      req_gray[11:8] = 4'b1011;
      #1;
      check("single_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check("single_valid", 32'(rsp_valid), 32'h1);
      check("single_bin", 32'(rsp_bin), 32'b1101);
      check("single_id", 32'(rsp_id), 32'd2);
      check("single_cnt", 32'(accept_cnt), 32'd1);
      rsp_ready = 1'b1;
      tick();
      check("drain_valid", 32'(rsp_valid), 32'h0);
      check("drain_bin_kept", 32'(rsp_bin), 32'b1101);
      check("drain_id_kept", 32'(rsp_id), 32'd2);

      // Fairness: all lanes valid, consumer always ready
      do_reset();
      for (int i = 0; i < 4; i++) req_gray[i*4 +: 4] = fair_gray[i];
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         tick();
         check("fair_valid", 32'(rsp_valid), 32'h1);
         check("fair_id", 32'(rsp_id), 32'(k % 4));
         check("fair_bin", 32'(rsp_bin), 32'(fair_bin[k % 4]));
      end
      check("fair_cnt", 32'(accept_cnt), 32'd6);
      req_valid = '0;
      tick();
      check("fair_drain", 32'(rsp_valid), 32'h0);

      // Backpressure
      do_reset();
      req_gray  = '0;
      req_gray[3:0] = 4'b1000;
      req_gray[7:4] = 4'b0110;
      req_gray[15:12] = 4'b1111;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #1;
      check("bp_first_ready", 32'(req_ready), 32'b0001);
      tick();
      check("bp_bin", 32'(rsp_bin), 32'b1111);
      check("bp_id", 32'(rsp_id), 32'd0);
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_stall_ready", 32'(req_ready), 32'h0);
         tick();
         check("bp_stall_valid", 32'(rsp_valid), 32'h1);
         check("bp_stall_bin", 32'(rsp_bin), 32'b1111);
         check("bp_stall_id", 32'(rsp_id), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'b0010);
      tick();
      check("bp_release_id", 32'(rsp_id), 32'd1);
      check("bp_release_bin", 32'(rsp_bin), 32'b0100);
      check("bp_release_cnt", 32'(accept_cnt), 32'd2);
      req_valid = '0;
      tick();

      // Exhaustive mapping through lane 3
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      for (int g = 0; g < 16; g++) begin
         req_gray[15:12] = 4'(g);
         #1;
         check("map_ready", 32'(req_ready), 32'b1000);
         tick();
         check("map_bin", 32'(rsp_bin), 32'(exp_bin[g]));
         check("map_id", 32'(rsp_id), 32'd3);
      end
      check("map_cnt", 32'(accept_cnt), 32'd16);
      req_valid = '0;
      tick();

      // Reset while a response is stalled
      do_reset();
      req_gray[3:0] = 4'b0101;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      tick();
      req_valid = '0;
      tick();
      check("mid_held_valid", 32'(rsp_valid), 32'h1);
      rst_n = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      tick();
      rst_n = 1'b1;
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_cnt", 32'(accept_cnt), 32'h0);
      #1;
      check("mid_first_grant", 32'(req_ready), 32'b0001);
      tick();
      check("mid_first_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      tick();

      // Counter wrap: 65536 back-to-back acceptances on lane 0
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      repeat (65535) @(posedge clk);
      #1;
      check("wrap_allones", 32'(accept_cnt), 32'hFFFF);
      tick();
      check("wrap_zero", 32'(accept_cnt), 32'h0);
      tick();
      check("wrap_continue", 32'(accept_cnt), 32'h1);
      req_valid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
